// File: rtl/sha_msg_feeder_if.sv
// Message-block handshake between sha_msg_feeder and the message-schedule stage.
interface sha_msg_feeder_if;
  logic [511:0] M;
  logic         en;
  logic         ready;
  logic         block_sel;
  logic [31:0]  nonce_cur;

  modport master (output M, en, block_sel, nonce_cur, input ready);
  modport slave  (input M, en, block_sel, nonce_cur, output ready);
endinterface

// File: rtl/sha_msg_feeder.sv
// Builds the two padded SHA-256 blocks of an 80-byte header for each nonce in a range.
// Optional macro SHA_MIDSTATE_EN: block 0 only for the first nonce, then block 1 per nonce.
module sha_msg_feeder #(
  parameter int unsigned MSG_LEN_BITS = 640
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [607:0]            header,
  input  logic [31:0]             nonce_start,
  input  logic [31:0]             nonce_end,
  output logic                    busy,
  output logic                    done,
  sha_msg_feeder_if.master        msg
);

  typedef enum logic [1:0] {IDLE, EMIT0, EMIT1, FIN} state_t;

  state_t       state_q, state_d;
  logic [607:0] hdr_q, hdr_d;
  logic [31:0]  nonce_q, nonce_d;
  logic [31:0]  nend_q, nend_d;
  logic         stop_pend_q, stop_pend_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         en_q, en_d;
  logic         bsel_q, bsel_d;
  logic [511:0] m_q, m_d;
  logic         xfer;
  logic         last;

  function automatic logic [511:0] block1(input logic [95:0] tail, input logic [31:0] n);
    return {tail, n, 32'h8000_0000, 320'd0, MSG_LEN_BITS[31:0]};
  endfunction

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    nonce_d     = nonce_q;
    nend_d      = nend_q;
    stop_pend_d = stop_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    en_d        = en_q;
    bsel_d      = bsel_q;
    m_d         = m_q;
    xfer        = en_q && msg.ready;
    last        = (nonce_q == nend_q) || stop_pend_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          hdr_d       = header;
          nonce_d     = nonce_start;
          nend_d      = nonce_end;
          stop_pend_d = 1'b0;
          busy_d      = 1'b1;
          en_d        = 1'b1;
          bsel_d      = 1'b0;
          m_d         = header[607:96];
          state_d     = EMIT0;
        end
      end
      EMIT0: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          bsel_d  = 1'b1;
          m_d     = block1(hdr_q[95:0], nonce_q);
          state_d = EMIT1;
        end
      end
      EMIT1: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          if (last) begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            nonce_d = nonce_q + 32'd1;
`ifdef SHA_MIDSTATE_EN
            // Midstate of block 0 is reused downstream, so only block 1 repeats.
            m_d     = block1(hdr_q[95:0], nonce_q + 32'd1);
`else
            bsel_d  = 1'b0;
            m_d     = hdr_q[607:96];
            state_d = EMIT0;
`endif
          end
        end
      end
      FIN: begin
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      nonce_q     <= '0;
      nend_q      <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      bsel_q      <= 1'b0;
      m_q         <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      nonce_q     <= nonce_d;
      nend_q      <= nend_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      en_q        <= en_d;
      bsel_q      <= bsel_d;
      m_q         <= m_d;
    end
  end

  assign msg.M         = m_q;
  assign msg.en        = en_q;
  assign msg.block_sel = bsel_q;
  assign msg.nonce_cur = nonce_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Scoreboard bench for sha_msg_feeder: a job model fills the expected queue, a monitor drains it.
module tb_sha_msg_feeder;

  logic         clk = 1'b0;
  logic         reset, start, stop;
  logic [607:0] header;
  logic [31:0]  nonce_start, nonce_end;
  logic         busy, done;

  sha_msg_feeder_if bus();

  sha_msg_feeder #(.MSG_LEN_BITS(640)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .header(header),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .busy(busy), .done(done),
    .msg(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         bsel;
    logic [31:0]  n;
    logic [511:0] m;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] hw[19];
  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] words16(input logic [31:0] w[16]);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r = {r[479:0], w[k]};
    return r;
  endfunction

  task automatic push(input logic b, input logic [31:0] n);
    logic [31:0] w[16];
    exp_t e;
    for (int k = 0; k < 16; k++) w[k] = 32'd0;
    if (!b) begin
      for (int k = 0; k < 16; k++) w[k] = hw[k];
    end else begin
      w[0] = hw[16]; w[1] = hw[17]; w[2] = hw[18];
      w[3] = n; w[4] = 32'h8000_0000; w[15] = 32'd640;
    end
    e.bsel = b; e.n = n; e.m = words16(w);
    exp_q.push_back(e);
  endtask

  task automatic load_header(input bit seq);
    for (int k = 0; k < 19; k++) begin
      hw[k] = seq ? 32'(k) : $urandom;
      header[607 - 32*k -: 32] = hw[k];
    end
  endtask

  // Monitor: pops expected blocks on every transfer and checks hold/done rules.
  logic         hold_pending = 1'b0;
  logic [511:0] hold_m;
  logic         hold_b;
  logic [31:0]  hold_n;

  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_en", bus.en, 1);
        chk("hold_M", bus.M, hold_m);
        chk("hold_block_sel", bus.block_sel, hold_b);
        chk("hold_nonce", bus.nonce_cur, hold_n);
      end
      if (bus.en && bus.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_xfer: got block_sel=%0d nonce=%0h expected no transfer",
                   bus.block_sel, bus.nonce_cur);
        end else begin
          mon_e = exp_q.pop_front();
          chk("xfer_block_sel", bus.block_sel, mon_e.bsel);
          chk("xfer_nonce", bus.nonce_cur, mon_e.n);
          chk("xfer_M", bus.M, mon_e.m);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_en_exclusive", bus.en, 0);
        chk("done_queue_drained", exp_q.size(), 0);
      end
      hold_pending = bus.en && !bus.ready;
      hold_m = bus.M; hold_b = bus.block_sel; hold_n = bus.nonce_cur;
    end
  end

  // stop_mode: 0 none, 1 pulse in first EMIT0, 2 asserted together with start in IDLE.
  // ready_mode: 0 always 1, 1 random, 2 low for cycles 1..3 (block 1 of first nonce).
  task automatic run_job(input logic [31:0] s, input logic [31:0] e, input int stop_mode,
                         input int ready_mode, input bit seq);
    logic [31:0] n;
    bit          first, got;
    int          base, xfers;
    load_header(seq);
    n = s; first = 1'b1;
    forever begin
`ifdef SHA_MIDSTATE_EN
      if (first) push(1'b0, n);
`else
      push(1'b0, n);
`endif
      push(1'b1, n);
      if (n == e || stop_mode == 1) break;
      n = n + 32'd1;
      first = 1'b0;
    end
    xfers = exp_q.size();
    nonce_start = s; nonce_end = e; start = 1'b1; stop = (stop_mode == 2);
    base = done_cnt; got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop = (stop_mode == 1) && (i == 0);
      case (ready_mode)
        0:       bus.ready = 1'b1;
        2:       bus.ready = !(i >= 1 && i <= 3);
        default: bus.ready = ($urandom_range(0, 99) < 60);
      endcase
      if (done_cnt != base) begin
        got = 1'b1;
        if (ready_mode == 0) chk("done_latency", i, xfers + 1);
        if (ready_mode == 2) chk("done_latency_bp", i, xfers + 4);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("single_done", done_cnt - base, 1);
      end
    end
    stop = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL job_timeout: got no done expected done for range %0h..%0h", s, e);
      exp_q.delete();
    end
  endtask

  initial begin
    int base;
    logic [31:0] s;
    reset = 1'b1; start = 1'b0; stop = 1'b0; header = '0;
    nonce_start = '0; nonce_end = '0; bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", bus.en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_nonce", bus.nonce_cur, 0);
    chk("reset_block_sel", bus.block_sel, 0);
    chk("reset_M", bus.M, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_job(32'd5, 32'd7, 0, 0, 1'b1);
    run_job(32'd5, 32'd7, 0, 2, 1'b1);
    run_job(32'hFFFF_FFFE, 32'h0000_0001, 0, 1, 1'b0);
    run_job(32'd100, 32'd200, 1, 0, 1'b0);
    run_job(32'd10, 32'd12, 2, 0, 1'b0);
    run_job(32'd0, 32'd3, 0, 0, 1'b0);
    s = $urandom;
    run_job(s, s, 0, 0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      s = $urandom;
      run_job(s, s + 32'($urandom_range(0, 5)), 0, 1, 1'b0);
    end

    // Reset in the middle of a job, after a start that arrives while busy.
    load_header(1'b0);
    push(1'b0, 32'd0);
    nonce_start = 32'd0; nonce_end = 32'd1000; start = 1'b1;
    @(posedge clk); #1;
    nonce_start = 32'd999; start = 1'b1; bus.ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.ready = 1'b0;
    chk("busy_start_ignored_nonce", bus.nonce_cur, 0);
    chk("busy_start_ignored_sel", bus.block_sel, 1);
    reset = 1'b1;
    base = done_cnt;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_en", bus.en, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_nonce", bus.nonce_cur, 0);
    chk("midreset_queue", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cnt - base, 0);

    s = $urandom;
    run_job(s, s + 32'd2, 0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha_msg_feeder.md
Name: sha_msg_feeder

Overview:
- Upstream stage of the bitcoin miner hash pipeline, sitting directly before the message-schedule start stage.
- Takes a 76-byte block header (everything except the nonce) and a nonce range.
- For each nonce, builds the two padded 512-bit SHA-256 message blocks of the 80-byte header and presents them, one per transfer, on a valid/ready handshake.
- Iterates the nonce over the range without software involvement.

Parameters:
- MSG_LEN_BITS, 640, message length in bits; written into the length field of block 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle job start; honoured only when busy=0
- stop  input  1  early-abort request; sampled every cycle
- header  input  608  header words 0..18; header[607:576] is word 0
- nonce_start  input  32  first nonce of the job
- nonce_end  input  32  last nonce of the job (inclusive)
- ready  input  1  downstream can accept M this cycle
- M  output  512  message block; M[511:480] is SHA word 0
- en  output  1  M valid; transfer occurs when en=1 and ready=1 at a rising edge
- block_sel  output  1  0 = block 0 (header words 0..15), 1 = block 1 (padded tail)
- nonce_cur  output  32  nonce carried by the current pair
- busy  output  1  job in progress
- done  output  1  one-cycle pulse when the job ends

Behaviour:
- Reset (sync, active-high): M=0, en=0, block_sel=0, nonce_cur=0, busy=0, done=0, stop_pend=0, state=IDLE. Asserting reset mid-job aborts the job at that edge: en drops, no done pulse.
- States: IDLE, EMIT0, EMIT1, FIN.
- IDLE, start=1: latch header, nonce_cur<=nonce_start, busy<=1, go to EMIT0. en=1 with block 0 on the next cycle (1-cycle latency).
- EMIT0: M = header words 0..15, block_sel=0, en=1. On transfer, go to EMIT1.
- EMIT1: block_sel=1, en=1, M laid out as:
  - words 0..2 = header words 16..18
  - word 3 = nonce_cur, inserted as-is with no byte swap
  - word 4 = 0x80000000
  - words 5..14 = 0
  - word 15 = MSG_LEN_BITS
- EMIT1 transfer, end condition: if nonce_cur==nonce_end or stop_pend=1, go to FIN.
- EMIT1 transfer, otherwise: nonce_cur<=nonce_cur+1 (mod 2^32), go to EMIT0.
- FIN: en=0, done=1 for exactly one cycle, busy<=0, stop_pend<=0, go to IDLE.
- Handshake rules:
  - While en=1 and ready=0, M, block_sel and nonce_cur hold stable.
  - en never drops without a transfer, except on reset.
  - With ready held at 1: one block per cycle, 2 cycles per nonce.
- stop:
  - stop=1 while busy sets stop_pend.
  - The job ends after the next EMIT1 transfer; a block pair is never split.
  - stop is ignored in IDLE.
- start while busy is ignored.
- start and stop asserted in the same IDLE cycle: start is taken, stop is ignored.
- Wrap-around: if nonce_end < nonce_start, the counter wraps 0xFFFFFFFF->0x00000000 and continues until it equals nonce_end.
- nonce_start==nonce_end: exactly one pair is emitted.
- done and en are never high in the same cycle.

Optional Feature:
- Macro: SHA_MIDSTATE_EN.
- When defined:
  - Block 0 is emitted only for the first nonce of a job.
  - Each later nonce goes EMIT1 -> EMIT1 directly: nonce_cur increments on each EMIT1 transfer and the state stays EMIT1.
  - Throughput is 1 cycle per nonce with ready=1.
  - Downstream reuses the block-0 midstate.
- When undefined: every nonce emits block 0 then block 1, as described in Behaviour.

Test Plan:
- Sequential header (word i = i), nonce_start=5, nonce_end=7, ready=1 -> 6 transfers.
  - block_sel 0,1,0,1,0,1; nonce_cur 5,5,6,6,7,7.
  - Block 1: M[511:480]=0x00000010, M[415:384]=nonce, M[383:352]=0x80000000, M[31:0]=0x00000280.
  - done pulses 1 cycle after the last transfer; busy then drops.
- Backpressure: ready=0 for 3 cycles during EMIT1 of nonce 5 -> en stays 1; M, block_sel=1 and nonce_cur=5 hold stable; the next transfer occurs when ready returns.
- Wrap: nonce_start=0xFFFFFFFE, nonce_end=0x00000001 -> pair nonces FFFFFFFE, FFFFFFFF, 00000000, 00000001, then done.
- stop pulse during EMIT0 of nonce 100 (range 100..200) -> the block-1 transfer for nonce 100 still occurs, then done; no block for nonce 101.
- reset=1 during EMIT1 -> next cycle en=0, busy=0, nonce_cur=0, no done pulse. A start while busy (before the reset) must not restart the job.
- SHA_MIDSTATE_EN defined, range 0..3, ready=1 -> block_sel 0,1,1,1,1; nonce_cur 0,0,1,2,3; done after 5 transfers.
